tlb_array_ctrl: RTL and testbench

- Software-managed TLB array and its operation controller for the LoongArch32 MMU.
- Consumes the CSR images TLBEHI, TLBELO0, TLBELO1, TLBIDX and ASID on TLBWR and TLBFILL.
- Produces the per-entry fields that the TLBELO0, TLBELO1, TLBEHI and TLBIDX CSRs load on TLBRD, plus the TLBSRCH result.
- Sits directly downstream of the TLBELO CSRs, and upstream of them for TLBRD.

---
 rtl/tlb_array_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_tlb_array_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_array_ctrl.sv
// LoongArch32 software-managed TLB array with TLBWR/TLBFILL/TLBRD/TLBSRCH controller.
// Define TLB_INVTLB_EN to add the INVTLB port group and single-cycle invalidate logic.
module tlb_array_ctrl #(
  parameter int ENTRIES = 16,
  parameter int INDEX_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tlbwr_req,
  input  logic               tlbfill_req,
  input  logic               tlbrd_req,
  input  logic               tlbsrch_req,
  input  logic [INDEX_W-1:0] csr_tlbidx_idx,
  input  logic [5:0]         csr_tlbidx_ps,
  input  logic               csr_tlbidx_ne,
  input  logic [18:0]        csr_tlbehi_vppn,
  input  logic [31:0]        csr_tlbelo0,
  input  logic [31:0]        csr_tlbelo1,
  input  logic [9:0]         csr_asid,
`ifdef TLB_INVTLB_EN
  input  logic               inv_req,
  input  logic [4:0]         inv_op,
  input  logic [9:0]         inv_asid,
  input  logic [18:0]        inv_vppn,
`endif
  output logic               busy,
  output logic               TLBRD_en,
  output logic [19:0]        TLB_PPN_0_RD,
  output logic [19:0]        TLB_PPN_1_RD,
  output logic [5:0]         TLB_flags_0,
  output logic [5:0]         TLB_flags_1,
  output logic               TLB_G_0,
  output logic               TLB_G_1,
  output logic [18:0]        rd_vppn,
  output logic [5:0]         rd_ps,
  output logic [9:0]         rd_asid,
  output logic               rd_ne,
  output logic               srch_done,
  output logic               srch_hit,
  output logic [INDEX_W-1:0] srch_idx
);

  // Requests are single-cycle pulses accepted only in IDLE; anything else is dropped.
  typedef enum logic {IDLE, SRCH} state_e;

  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [5:0]  flags0;
    logic [19:0] ppn1;
    logic [5:0]  flags1;
  } fields_t;

  typedef struct packed {
    logic    e;
    fields_t f;
  } entry_t;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] scan_idx_q, scan_idx_d;
  logic [INDEX_W-1:0] fill_ptr_q, fill_ptr_d;
  entry_t             tlb_q [ENTRIES];
  entry_t             tlb_d [ENTRIES];
  fields_t            rd_q, rd_d;
  logic               rd_ne_q, rd_ne_d;
  logic               rd_en_q, rd_en_d;
  logic               done_q, done_d;
  logic               hit_q, hit_d;
  logic [INDEX_W-1:0] sidx_q, sidx_d;

  logic               idle, wr_go, fill_go, rd_go, srch_go;
  entry_t             new_entry;
  logic [INDEX_W-1:0] cmp_idx;
  logic               cmp_hit;

  function automatic logic vppn_eq(input logic [5:0] ps, input logic [18:0] a,
                                   input logic [18:0] b);
    if (ps == 6'd21) return a[18:9] == b[18:9];
    return a == b;
  endfunction

`ifdef TLB_INVTLB_EN
  logic inv_go;

  function automatic logic inv_hit(input entry_t ent, input logic [4:0] op,
                                   input logic [9:0] asid, input logic [18:0] vppn);
    logic am, vm, res;
    am = (ent.f.asid == asid);
    vm = vppn_eq(ent.f.ps, ent.f.vppn, vppn);
    case (op)
      5'd0, 5'd1: res = 1'b1;
      5'd2:       res = ent.f.g;
      5'd3:       res = ~ent.f.g;
      5'd4:       res = ~ent.f.g & am;
      5'd5:       res = ~ent.f.g & am & vm;
      5'd6:       res = (ent.f.g | am) & vm;
      default:    res = 1'b0;
    endcase
    return res;
  endfunction

  assign inv_go = idle & ~tlbwr_req & ~tlbfill_req & ~tlbrd_req & ~tlbsrch_req & inv_req;
`endif

  assign idle    = (state_q == IDLE);
  assign wr_go   = idle & tlbwr_req;
  assign fill_go = idle & ~tlbwr_req & tlbfill_req;
  assign rd_go   = idle & ~tlbwr_req & ~tlbfill_req & tlbrd_req;
  assign srch_go = idle & ~tlbwr_req & ~tlbfill_req & ~tlbrd_req & tlbsrch_req;

  always_comb begin
    new_entry          = '0;
    new_entry.e        = ~csr_tlbidx_ne;
    new_entry.f.vppn   = csr_tlbehi_vppn;
    new_entry.f.ps     = csr_tlbidx_ps;
    new_entry.f.asid   = csr_asid;
    new_entry.f.g      = csr_tlbelo0[6] & csr_tlbelo1[6];
    new_entry.f.ppn0   = csr_tlbelo0[27:8];
    new_entry.f.flags0 = csr_tlbelo0[5:0];
    new_entry.f.ppn1   = csr_tlbelo1[27:8];
    new_entry.f.flags1 = csr_tlbelo1[5:0];
  end

  // Entry 0 is compared in the request cycle itself so a hit at k completes k+1 cycles later.
  assign cmp_idx = idle ? '0 : scan_idx_q;
  assign cmp_hit = tlb_q[cmp_idx].e &&
                   (tlb_q[cmp_idx].f.g || (tlb_q[cmp_idx].f.asid == csr_asid)) &&
                   vppn_eq(tlb_q[cmp_idx].f.ps, tlb_q[cmp_idx].f.vppn, csr_tlbehi_vppn);

  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    fill_ptr_d = fill_ptr_q;
    for (int i = 0; i < ENTRIES; i++) tlb_d[i] = tlb_q[i];
    rd_d       = rd_q;
    rd_ne_d    = rd_ne_q;
    rd_en_d    = 1'b0;
    done_d     = 1'b0;
    hit_d      = hit_q;
    sidx_d     = sidx_q;

    if (wr_go) tlb_d[csr_tlbidx_idx] = new_entry;

    if (fill_go) begin
      tlb_d[fill_ptr_q] = new_entry;
      fill_ptr_d        = fill_ptr_q + INDEX_W'(1);
    end

    if (rd_go) begin
      rd_en_d = 1'b1;
      rd_ne_d = ~tlb_q[csr_tlbidx_idx].e;
      rd_d    = tlb_q[csr_tlbidx_idx].e ? tlb_q[csr_tlbidx_idx].f : '0;
    end

    if (srch_go) begin
      if (cmp_hit) begin
        done_d = 1'b1;
        hit_d  = 1'b1;
        sidx_d = '0;
      end else begin
        state_d    = SRCH;
        scan_idx_d = INDEX_W'(1);
      end
    end else if (state_q == SRCH) begin
      if (cmp_hit) begin
        done_d  = 1'b1;
        hit_d   = 1'b1;
        sidx_d  = scan_idx_q;
        state_d = IDLE;
      end else if (scan_idx_q == INDEX_W'(ENTRIES - 1)) begin
        done_d  = 1'b1;
        hit_d   = 1'b0;
        sidx_d  = '0;
        state_d = IDLE;
      end else begin
        scan_idx_d = scan_idx_q + INDEX_W'(1);
      end
    end

`ifdef TLB_INVTLB_EN
    if (inv_go) begin
      for (int i = 0; i < ENTRIES; i++)
        if (inv_hit(tlb_q[i], inv_op, inv_asid, inv_vppn)) tlb_d[i].e = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      scan_idx_q <= '0;
      fill_ptr_q <= '0;
      for (int i = 0; i < ENTRIES; i++) tlb_q[i] <= '0;
      rd_q       <= '0;
      rd_ne_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      sidx_q     <= '0;
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      fill_ptr_q <= fill_ptr_d;
      for (int i = 0; i < ENTRIES; i++) tlb_q[i] <= tlb_d[i];
      rd_q       <= rd_d;
      rd_ne_q    <= rd_ne_d;
      rd_en_q    <= rd_en_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      sidx_q     <= sidx_d;
    end
  end

  assign busy         = (state_q == SRCH);
  assign TLBRD_en     = rd_en_q;
  assign TLB_PPN_0_RD = rd_q.ppn0;
  assign TLB_PPN_1_RD = rd_q.ppn1;
  assign TLB_flags_0  = rd_q.flags0;
  assign TLB_flags_1  = rd_q.flags1;
  assign TLB_G_0      = rd_q.g;
  assign TLB_G_1      = rd_q.g;
  assign rd_vppn      = rd_q.vppn;
  assign rd_ps        = rd_q.ps;
  assign rd_asid      = rd_q.asid;
  assign rd_ne        = rd_ne_q;
  assign srch_done    = done_q;
  assign srch_hit     = hit_q;
  assign srch_idx     = sidx_q;

endmodule

// File: tb/tb_tlb_array_ctrl.sv
// Directed bench for tlb_array_ctrl: write/read, fill wrap, search hit/miss/ps21, reset mid-search.
module tb_tlb_array_ctrl;
  localparam int ENTRIES = 16;
  localparam int INDEX_W = 4;

  logic               clk, rst_n;
  logic               tlbwr_req, tlbfill_req, tlbrd_req, tlbsrch_req;
  logic [INDEX_W-1:0] csr_tlbidx_idx;
  logic [5:0]         csr_tlbidx_ps;
  logic               csr_tlbidx_ne;
  logic [18:0]        csr_tlbehi_vppn;
  logic [31:0]        csr_tlbelo0, csr_tlbelo1;
  logic [9:0]         csr_asid;
  logic               busy, TLBRD_en;
  logic [19:0]        TLB_PPN_0_RD, TLB_PPN_1_RD;
  logic [5:0]         TLB_flags_0, TLB_flags_1;
  logic               TLB_G_0, TLB_G_1;
  logic [18:0]        rd_vppn;
  logic [5:0]         rd_ps;
  logic [9:0]         rd_asid;
  logic               rd_ne, srch_done, srch_hit;
  logic [INDEX_W-1:0] srch_idx;
`ifdef TLB_INVTLB_EN
  logic               inv_req;
  logic [4:0]         inv_op;
  logic [9:0]         inv_asid;
  logic [18:0]        inv_vppn;
`endif

  int checks = 0;
  int failures = 0;

  tlb_array_ctrl #(.ENTRIES(ENTRIES), .INDEX_W(INDEX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .tlbwr_req(tlbwr_req), .tlbfill_req(tlbfill_req),
    .tlbrd_req(tlbrd_req), .tlbsrch_req(tlbsrch_req),
    .csr_tlbidx_idx(csr_tlbidx_idx), .csr_tlbidx_ps(csr_tlbidx_ps),
    .csr_tlbidx_ne(csr_tlbidx_ne), .csr_tlbehi_vppn(csr_tlbehi_vppn),
    .csr_tlbelo0(csr_tlbelo0), .csr_tlbelo1(csr_tlbelo1), .csr_asid(csr_asid),
`ifdef TLB_INVTLB_EN
    .inv_req(inv_req), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
`endif
    .busy(busy), .TLBRD_en(TLBRD_en),
    .TLB_PPN_0_RD(TLB_PPN_0_RD), .TLB_PPN_1_RD(TLB_PPN_1_RD),
    .TLB_flags_0(TLB_flags_0), .TLB_flags_1(TLB_flags_1),
    .TLB_G_0(TLB_G_0), .TLB_G_1(TLB_G_1),
    .rd_vppn(rd_vppn), .rd_ps(rd_ps), .rd_asid(rd_asid), .rd_ne(rd_ne),
    .srch_done(srch_done), .srch_hit(srch_hit), .srch_idx(srch_idx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers: inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_csr(input logic [INDEX_W-1:0] idx, input logic [5:0] ps, input logic ne,
                         input logic [18:0] vppn, input logic [31:0] elo0,
                         input logic [31:0] elo1, input logic [9:0] asid);
    csr_tlbidx_idx  = idx;
    csr_tlbidx_ps   = ps;
    csr_tlbidx_ne   = ne;
    csr_tlbehi_vppn = vppn;
    csr_tlbelo0     = elo0;
    csr_tlbelo1     = elo1;
    csr_asid        = asid;
  endtask

  task automatic pulse_wr();
    tlbwr_req = 1'b1; tick(); tlbwr_req = 1'b0;
  endtask

  task automatic pulse_fill();
    tlbfill_req = 1'b1; tick(); tlbfill_req = 1'b0;
  endtask

  // leaves the bench in the cycle where TLBRD_en should be high
  task automatic do_rd(input logic [INDEX_W-1:0] idx);
    csr_tlbidx_idx = idx;
    tlbrd_req = 1'b1; tick(); tlbrd_req = 1'b0;
  endtask

  // issues TLBSRCH, returns the cycle srch_done rose (-1 on timeout) and busy observations
  task automatic run_srch(input bit poke_rd, output int done_cyc, output int busy_cycles,
                          output bit busy_at_done, output bit rd_seen);
    done_cyc = -1; busy_cycles = 0; busy_at_done = 1'b0; rd_seen = 1'b0;
    tlbsrch_req = 1'b1; tick(); tlbsrch_req = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (TLBRD_en) rd_seen = 1'b1;
      if (srch_done) begin
        done_cyc = c; busy_at_done = busy;
        break;
      end
      if (busy) busy_cycles++;
      tlbrd_req = (poke_rd && c == 3);
      tick();
    end
    tlbrd_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tlbwr_req = 0; tlbfill_req = 0; tlbrd_req = 0; tlbsrch_req = 0;
`ifdef TLB_INVTLB_EN
    inv_req = 0; inv_op = 0; inv_asid = 0; inv_vppn = 0;
`endif
    set_csr(0, 6'd12, 0, 0, 0, 0, 0);
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (TLBRD_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%0h exp=0", TLBRD_en); end
    checks++; if ({srch_done, srch_hit, srch_idx} !== '0) begin failures++; $display("FAIL reset_srch got=%0h exp=0", {srch_done, srch_hit, srch_idx}); end
    checks++; if ({rd_ne, rd_vppn, rd_ps, rd_asid, TLB_PPN_0_RD, TLB_G_0} !== '0) begin failures++; $display("FAIL reset_rd_fields got=%0h exp=0", {rd_ne, rd_vppn, rd_ps, rd_asid, TLB_PPN_0_RD, TLB_G_0}); end
    rst_n = 1'b1;
    tick();
    do_rd(0);
    checks++; if (rd_ne !== 1'b1) begin failures++; $display("FAIL reset_entry0_ne got=%0h exp=1", rd_ne); end
    tick();
  endtask

  task automatic test_wr_rd();
    set_csr(3, 6'd12, 0, 19'h12345, 32'h0ABCDE4F, 32'h0123454D, 10'h05);
    pulse_wr();
    do_rd(3);
    checks++; if (TLBRD_en !== 1'b1) begin failures++; $display("FAIL wr_rd_en got=%0h exp=1", TLBRD_en); end
    checks++; if (TLB_PPN_0_RD !== 20'h0ABCDE) begin failures++; $display("FAIL wr_ppn0 got=%0h exp=0abcde", TLB_PPN_0_RD); end
    checks++; if (TLB_flags_0 !== 6'h0F) begin failures++; $display("FAIL wr_flags0 got=%0h exp=0f", TLB_flags_0); end
    checks++; if (TLB_PPN_1_RD !== 20'h012345) begin failures++; $display("FAIL wr_ppn1 got=%0h exp=012345", TLB_PPN_1_RD); end
    checks++; if (TLB_flags_1 !== 6'h0D) begin failures++; $display("FAIL wr_flags1 got=%0h exp=0d", TLB_flags_1); end
    checks++; if ({TLB_G_0, TLB_G_1} !== 2'b11) begin failures++; $display("FAIL wr_g got=%0h exp=3", {TLB_G_0, TLB_G_1}); end
    checks++; if (rd_ne !== 1'b0) begin failures++; $display("FAIL wr_ne got=%0h exp=0", rd_ne); end
    checks++; if (rd_vppn !== 19'h12345) begin failures++; $display("FAIL wr_vppn got=%0h exp=12345", rd_vppn); end
    checks++; if ({rd_ps, rd_asid} !== {6'd12, 10'h05}) begin failures++; $display("FAIL wr_ps_asid got=%0h exp=%0h", {rd_ps, rd_asid}, {6'd12, 10'h05}); end
    tick();
    checks++; if (TLBRD_en !== 1'b0) begin failures++; $display("FAIL wr_rd_en_pulse got=%0h exp=0", TLBRD_en); end
    checks++; if (rd_vppn !== 19'h12345) begin failures++; $display("FAIL wr_vppn_hold got=%0h exp=12345", rd_vppn); end
  endtask

  task automatic test_rd_empty();
    do_rd(7);
    checks++; if (TLBRD_en !== 1'b1) begin failures++; $display("FAIL empty_rd_en got=%0h exp=1", TLBRD_en); end
    checks++; if (rd_ne !== 1'b1) begin failures++; $display("FAIL empty_ne got=%0h exp=1", rd_ne); end
    checks++; if ({rd_vppn, rd_ps, rd_asid, TLB_PPN_0_RD, TLB_PPN_1_RD, TLB_flags_0, TLB_flags_1, TLB_G_0, TLB_G_1} !== '0) begin
      failures++; $display("FAIL empty_fields got=%0h exp=0", {rd_vppn, rd_ps, rd_asid, TLB_PPN_0_RD, TLB_PPN_1_RD, TLB_flags_0, TLB_flags_1, TLB_G_0, TLB_G_1});
    end
    tick();
  endtask

  task automatic test_arb();
    set_csr(5, 6'd12, 0, 19'h55555, 32'h00000103, 32'h00000203, 10'h05);
    tlbwr_req = 1'b1; tlbrd_req = 1'b1; tick(); tlbwr_req = 1'b0; tlbrd_req = 1'b0;
    checks++; if (TLBRD_en !== 1'b0) begin failures++; $display("FAIL arb_rd_dropped got=%0h exp=0", TLBRD_en); end
    do_rd(5);
    checks++; if ({rd_ne, rd_vppn} !== {1'b0, 19'h55555}) begin failures++; $display("FAIL arb_wr_won got=%0h exp=%0h", {rd_ne, rd_vppn}, {1'b0, 19'h55555}); end
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i <= ENTRIES; i++) begin
      set_csr(0, 6'd12, 0, (i == ENTRIES) ? 19'h001FF : 19'(32'h100 + i),
              32'h00000003 | (i << 8), 32'h00000001, 10'h05);
      pulse_fill();
    end
    do_rd(0);
    checks++; if (rd_vppn !== 19'h001FF) begin failures++; $display("FAIL fill_wrap_e0 got=%0h exp=1ff", rd_vppn); end
    do_rd(15);
    checks++; if ({rd_vppn, TLB_PPN_0_RD} !== {19'h0010F, 20'h0000F}) begin failures++; $display("FAIL fill_e15 got=%0h exp=%0h", {rd_vppn, TLB_PPN_0_RD}, {19'h0010F, 20'h0000F}); end
    do_rd(5);
    checks++; if ({rd_vppn, TLB_G_0} !== {19'h00105, 1'b0}) begin failures++; $display("FAIL fill_e5 got=%0h exp=%0h", {rd_vppn, TLB_G_0}, {19'h00105, 1'b0}); end
    set_csr(0, 6'd12, 0, 19'h000AA, 32'h00000003, 32'h00000001, 10'h05);
    pulse_fill();
    do_rd(1);
    checks++; if (rd_vppn !== 19'h000AA) begin failures++; $display("FAIL fill_ptr_1 got=%0h exp=aa", rd_vppn); end
    do_rd(0);
    checks++; if (rd_vppn !== 19'h001FF) begin failures++; $display("FAIL fill_e0_kept got=%0h exp=1ff", rd_vppn); end
    tick();
  endtask

  task automatic test_srch_hit();
    int dc, bc; bit bd, rs;
    set_csr(0, 6'd12, 0, 19'h00109, 0, 0, 10'h05);
    run_srch(1'b1, dc, bc, bd, rs);
    checks++; if (dc !== 10) begin failures++; $display("FAIL hit_done_cycle got=%0d exp=10", dc); end
    checks++; if (bc !== 9) begin failures++; $display("FAIL hit_busy_cycles got=%0d exp=9", bc); end
    checks++; if (bd !== 1'b0) begin failures++; $display("FAIL hit_busy_at_done got=%0h exp=0", bd); end
    checks++; if (rs !== 1'b0) begin failures++; $display("FAIL hit_rd_while_busy got=%0h exp=0", rs); end
    checks++; if ({srch_hit, srch_idx} !== {1'b1, 4'd9}) begin failures++; $display("FAIL hit_result got=%0h exp=%0h", {srch_hit, srch_idx}, {1'b1, 4'd9}); end
    tick();
    checks++; if ({srch_done, srch_hit, srch_idx} !== {1'b0, 1'b1, 4'd9}) begin failures++; $display("FAIL hit_hold got=%0h exp=%0h", {srch_done, srch_hit, srch_idx}, {1'b0, 1'b1, 4'd9}); end
  endtask

  task automatic test_srch_miss();
    int dc, bc; bit bd, rs;
    csr_asid = 10'h06;
    run_srch(1'b0, dc, bc, bd, rs);
    checks++; if (dc !== 16) begin failures++; $display("FAIL miss_done_cycle got=%0d exp=16", dc); end
    checks++; if (bc !== 15) begin failures++; $display("FAIL miss_busy_cycles got=%0d exp=15", bc); end
    checks++; if ({srch_hit, srch_idx} !== 5'd0) begin failures++; $display("FAIL miss_result got=%0h exp=0", {srch_hit, srch_idx}); end
    tick();
  endtask

  task automatic test_srch_ps21();
    int dc, bc; bit bd, rs;
    set_csr(12, 6'd21, 0, 19'h12345, 32'h00000003, 32'h00000001, 10'h05);
    pulse_wr();
    csr_tlbehi_vppn = 19'h123FF;
    run_srch(1'b0, dc, bc, bd, rs);
    checks++; if (dc !== 13) begin failures++; $display("FAIL ps21_done_cycle got=%0d exp=13", dc); end
    checks++; if ({srch_hit, srch_idx} !== {1'b1, 4'd12}) begin failures++; $display("FAIL ps21_result got=%0h exp=%0h", {srch_hit, srch_idx}, {1'b1, 4'd12}); end
    tick();
  endtask

  task automatic test_reset_mid();
    bit done_seen;
    done_seen = 1'b0;
    set_csr(9, 6'd12, 0, 19'h00109, 0, 0, 10'h06);
    tlbsrch_req = 1'b1; tick(); tlbsrch_req = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%0h exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy_reset got=%0h exp=0", busy); end
    checks++; if (srch_hit !== 1'b0) begin failures++; $display("FAIL mid_hit_reset got=%0h exp=0", srch_hit); end
    repeat (2) begin tick(); if (srch_done) done_seen = 1'b1; end
    rst_n = 1'b1;
    repeat (3) begin tick(); if (srch_done) done_seen = 1'b1; end
    checks++; if (done_seen !== 1'b0) begin failures++; $display("FAIL mid_no_done got=%0h exp=0", done_seen); end
    do_rd(9);
    checks++; if ({TLBRD_en, rd_ne} !== 2'b11) begin failures++; $display("FAIL mid_entry_invalid got=%0h exp=3", {TLBRD_en, rd_ne}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_wr_rd();
    test_rd_empty();
    test_arb();
    test_fill();
    test_srch_hit();
    test_srch_miss();
    test_srch_ps21();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
